mux_nx1_sync: RTL and testbench

Registered, parametrised N-to-1 sample multiplexer for the FFT datapath; the next generation of the team's 2:1 combinational mux. Selects one of `NUM_INPUTS` signed lanes per valid sample, either from an external select or from an internal rotating counter (commutator mode) that advances every `PERIOD` valid samples. Sits between butterfly stages and delay-feedback lines, where stage controllers need a registered, valid-qualified, self-sequencing switch.

---
 rtl/fft_mux_pkg.sv | 12 +
 rtl/mux_sel_counter.sv | 55 +++++
 rtl/mux_nx1_sync.sv | 75 +++++++
 tb/tb_mux_nx1_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_mux_pkg.sv
// Shared definitions for the FFT datapath sample multiplexers.
package fft_mux_pkg;

    localparam logic MODE_EXT  = 1'b0;
    localparam logic MODE_AUTO = 1'b1;

    // Bits needed to index n items; a single item still gets one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Rotating select generator for commutator mode: per_cnt counts valid
// samples within one select step, sel_cnt walks the lanes.
module mux_sel_counter
    import fft_mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int PERIOD     = 1,
    localparam int SEL_W      = sel_width(NUM_INPUTS),
    localparam int PER_W      = sel_width(PERIOD)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,    // valid sample consumed in auto mode
    input  logic             clear_i,  // synchronous restart
    output logic [SEL_W-1:0] sel_o,    // select for the sample this cycle
    output logic             wrap_o    // this sample closes a full rotation
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

    logic [SEL_W-1:0] sel_q, sel_d, base_sel;
    logic [PER_W-1:0] per_q, per_d, base_per;

    // Clear makes the current sample behave as the first one of a rotation,
    // so the advance logic simply starts from a zeroed base.
    always_comb begin
        base_sel = clear_i ? '0 : sel_q;
        base_per = clear_i ? '0 : per_q;
        sel_d    = base_sel;
        per_d    = base_per;
        if (adv_i) begin
            if (base_per == PER_LAST) begin
                per_d = '0;
                sel_d = (base_sel == SEL_LAST) ? '0 : base_sel + SEL_W'(1);
            end else begin
                per_d = base_per + PER_W'(1);
            end
        end
        sel_o  = base_sel;
        wrap_o = adv_i & ~clear_i & (sel_q == SEL_LAST) & (per_q == PER_LAST);
    end

    // Counter state; reset discards any partial rotation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
            per_q <= '0;
        end else begin
            sel_q <= sel_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/mux_nx1_sync.sv
// Registered N-to-1 sample mux with external or self-rotating select.
module mux_nx1_sync
    import fft_mux_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int NUM_INPUTS = 4,
    parameter  int PERIOD     = 1,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_INPUTS*WIDTH-1:0] Input_Bus,
    input  logic                        In_Valid,
    input  logic                        Mode,
    input  logic [SEL_W-1:0]            Selection,
    input  logic                        Clear,
    output logic signed [WIDTH-1:0]     Output_Mux,
    output logic                        Out_Valid,
    output logic [SEL_W-1:0]            Sel_Out,
    output logic                        Wrap
);

    logic [NUM_INPUTS-1:0][WIDTH-1:0] lane;
    logic [SEL_W-1:0] cnt_sel, eff_sel, sel_q;
    logic [WIDTH-1:0] out_d, out_q;
    logic             cnt_wrap, adv, vld_q, wrap_q;

    assign lane = Input_Bus;
    assign adv  = In_Valid & (Mode == MODE_AUTO);

    mux_sel_counter #(
        .NUM_INPUTS (NUM_INPUTS),
        .PERIOD     (PERIOD)
    ) u_cnt (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .adv_i   (adv),
        .clear_i (Clear),
        .sel_o   (cnt_sel),
        .wrap_o  (cnt_wrap)
    );

    assign eff_sel = (Mode == MODE_AUTO) ? cnt_sel : Selection;

    // Lane select; an out-of-range index matches no lane and yields zero.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (eff_sel == SEL_W'(k)) out_d = lane[k];
        end
    end

    // Output register: data/select hold across gaps, valid and wrap pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q  <= '0;
            sel_q  <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            vld_q  <= In_Valid;
            wrap_q <= cnt_wrap;
            if (In_Valid) begin
                out_q <= out_d;
                sel_q <= eff_sel;
            end
        end
    end

    assign Output_Mux = out_q;
    assign Out_Valid  = vld_q;
    assign Sel_Out    = sel_q;
    assign Wrap       = wrap_q;

endmodule

// File: tb/tb_mux_nx1_sync.sv
// Bench for mux_nx1_sync: three configurations driven in lockstep and
// compared against a sample-count reference model.
module tb_mux_nx1_sync;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        vld_i = 1'b0, mode_i = 1'b0, clr_i = 1'b0;
    logic [1:0]  sel_i = '0;
    logic [15:0] ln [4];
    logic [63:0] bus4;
    logic [47:0] bus3;

    logic [2:0][15:0] o_out;
    logic [2:0]       o_vld, o_wrap;
    logic [2:0][1:0]  o_sel;

    int tests = 0;
    int fails = 0;

    // Reference state: k = auto-mode valid samples since reset/clear.
    int          k [3];
    logic [15:0] e_out [3];
    logic        e_vld [3];
    logic        e_wrap [3];
    logic [1:0]  e_sel [3];

    always #5 CLK = ~CLK;

    assign bus4 = {ln[3], ln[2], ln[1], ln[0]};
    assign bus3 = {ln[2], ln[1], ln[0]};

    mux_nx1_sync #(.WIDTH(16), .NUM_INPUTS(4), .PERIOD(1)) u_n4p1 (
        .CLK(CLK), .RST(RST), .Input_Bus(bus4), .In_Valid(vld_i), .Mode(mode_i),
        .Selection(sel_i), .Clear(clr_i), .Output_Mux(o_out[0]), .Out_Valid(o_vld[0]),
        .Sel_Out(o_sel[0]), .Wrap(o_wrap[0]));

    mux_nx1_sync #(.WIDTH(16), .NUM_INPUTS(4), .PERIOD(2)) u_n4p2 (
        .CLK(CLK), .RST(RST), .Input_Bus(bus4), .In_Valid(vld_i), .Mode(mode_i),
        .Selection(sel_i), .Clear(clr_i), .Output_Mux(o_out[1]), .Out_Valid(o_vld[1]),
        .Sel_Out(o_sel[1]), .Wrap(o_wrap[1]));

    mux_nx1_sync #(.WIDTH(16), .NUM_INPUTS(3), .PERIOD(1)) u_n3p1 (
        .CLK(CLK), .RST(RST), .Input_Bus(bus3), .In_Valid(vld_i), .Mode(mode_i),
        .Selection(sel_i), .Clear(clr_i), .Output_Mux(o_out[2]), .Out_Valid(o_vld[2]),
        .Sel_Out(o_sel[2]), .Wrap(o_wrap[2]));

    function automatic int nv(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int pv(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            k[d] = 0; e_out[d] = '0; e_vld[d] = 1'b0; e_wrap[d] = 1'b0; e_sel[d] = '0;
        end
    endfunction

    // One clock of the reference: lane index = (k / PERIOD) mod N,
    // rotation ends when k mod (N*PERIOD) is its last value.
    function automatic void model_step(input int d);
        int   n, p, s;
        logic w;
        n = nv(d);
        p = pv(d);
        if (!RST) begin
            k[d] = 0; e_out[d] = '0; e_vld[d] = 1'b0; e_wrap[d] = 1'b0; e_sel[d] = '0;
            return;
        end
        if (clr_i) k[d] = 0;
        if (vld_i) begin
            if (mode_i) begin
                s = (k[d] / p) % n;
                w = ((k[d] % (n * p)) == n * p - 1);
                k[d]++;
            end else begin
                s = int'(sel_i);
                w = 1'b0;
            end
            e_out[d]  = (s < n) ? ln[s] : 16'h0000;
            e_sel[d]  = 2'(s);
            e_vld[d]  = 1'b1;
            e_wrap[d] = w;
        end else begin
            e_vld[d]  = 1'b0;
            e_wrap[d] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out[%0d]", d),  32'(o_out[d]),  32'(e_out[d]));
            chk($sformatf("vld[%0d]", d),  32'(o_vld[d]),  32'(e_vld[d]));
            chk($sformatf("sel[%0d]", d),  32'(o_sel[d]),  32'(e_sel[d]));
            chk($sformatf("wrap[%0d]", d), 32'(o_wrap[d]), 32'(e_wrap[d]));
        end
    endtask

    // Inputs are stable here; advance the model, clock, then compare.
    task automatic tick();
        for (int d = 0; d < 3; d++) model_step(d);
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++) ln[i] = 16'($urandom);
    endtask

    initial begin
        logic v_pat [6];
        int   vcnt;
        for (int i = 0; i < 4; i++) ln[i] = '0;
        model_reset();

        // Reset held with random inputs: everything stays zero.
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_lanes();
            vld_i = 1'($urandom); mode_i = 1'($urandom);
            sel_i = 2'($urandom); clr_i = 1'($urandom);
            tick();
        end

        // Release, external select 2.
        RST = 1'b1; clr_i = 1'b0; mode_i = 1'b0; sel_i = 2'd2; vld_i = 1'b1;
        ln[0] = 16'h0001; ln[1] = 16'h0002; ln[2] = 16'h8003; ln[3] = 16'h7FFF;
        tick();
        chk("ext_sel2_out", 32'(o_out[0]), 32'h8003);
        chk("ext_sel2_sel", 32'(o_sel[0]), 32'd2);

        // Auto, 8 consecutive valids.
        mode_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_lanes();
            tick();
            chk("auto_seq_sel", 32'(o_sel[0]), 32'(i % 4));
            chk("auto_seq_wrap", 32'(o_wrap[0]), 32'((i % 4) == 3));
        end

        // PERIOD=2 with valid gaps after a clear-only cycle.
        vld_i = 1'b0; clr_i = 1'b1; tick(); clr_i = 1'b0;
        v_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            rand_lanes();
            vld_i = v_pat[i];
            tick();
            if (v_pat[i]) begin
                chk("p2_gap_sel", 32'(o_sel[1]), 32'(vcnt / 2));
                vcnt++;
            end else begin
                chk("p2_gap_vld", 32'(o_vld[1]), 32'd0);
            end
        end

        // Clear together with a valid while sel_cnt = 3.
        vld_i = 1'b0; clr_i = 1'b1; tick(); clr_i = 1'b0;
        vld_i = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_lanes(); tick(); end
        clr_i = 1'b1; rand_lanes(); tick(); clr_i = 1'b0;
        chk("clr_valid_sel", 32'(o_sel[0]), 32'd0);
        chk("clr_valid_wrap", 32'(o_wrap[0]), 32'd0);
        rand_lanes(); tick();
        chk("clr_next_sel", 32'(o_sel[0]), 32'd1);

        // Out-of-range external select on N=3, then resume auto.
        mode_i = 1'b0; sel_i = 2'd3; rand_lanes(); ln[0] = 16'h1234; tick();
        chk("oor_out", 32'(o_out[2]), 32'd0);
        chk("oor_vld", 32'(o_vld[2]), 32'd1);
        mode_i = 1'b1; rand_lanes(); tick();
        chk("resume_sel", 32'(o_sel[2]), 32'd2);

        // Async reset in the middle of a rotation.
        for (int i = 0; i < 2; i++) begin rand_lanes(); tick(); end
        #3 RST = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        RST = 1'b1; rand_lanes(); tick();
        chk("post_rst_sel", 32'(o_sel[0]), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            rand_lanes();
            vld_i  = ($urandom_range(0, 3) != 0);
            mode_i = ($urandom_range(0, 4) != 0);
            sel_i  = 2'($urandom);
            clr_i  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
